// File: rtl/mdu_ctrl_if.sv
// Opcode encodings and the E-stage <-> multiply/divide unit signal bundle.
package mdu_ctrl_pkg;
  localparam logic [7:0] ALUOP_MULT  = 8'h18;
  localparam logic [7:0] ALUOP_MULTU = 8'h19;
  localparam logic [7:0] ALUOP_DIV   = 8'h1A;
  localparam logic [7:0] ALUOP_DIVU  = 8'h1B;
  localparam logic [7:0] ALUOP_MTHI  = 8'h11;
  localparam logic [7:0] ALUOP_MTLO  = 8'h13;
endpackage

interface mdu_ctrl_if;
  logic        en_i;
  logic [7:0]  aluop_i;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stall_i;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;

  // E-stage side
  modport master (
    output en_i, aluop_i, src_a, src_b, stall_i, flush_i,
    input  stall_o, hi_o, lo_o, busy_o
  );

  // multiply/divide unit side
  modport slave (
    input  en_i, aluop_i, src_a, src_b, stall_i, flush_i,
    output stall_o, hi_o, lo_o, busy_o
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E-stage; owns the HI/LO registers.
//
// state | meaning
// IDLE  | accepts MULT/MULTU/DIV/DIVU issue and MTHI/MTLO writes
// BUSY  | operation in flight, cnt counts down to the HI/LO write at cnt==1
// DONE  | result written, waiting for the instruction to leave E
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input logic       clk,
  input logic       rst,
  mdu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT);
  localparam logic [5:0] DIV_CNT = 6'd33;

  state_t      state;
  logic [5:0]  cnt;
  logic        op_div;
  logic        op_sgn;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        is_mul_op;
  logic        is_div_op;
  logic        is_sgn_op;
  logic        is_md;
  logic        is_mt;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  assign is_mul_op = (bus.aluop_i == ALUOP_MULT) || (bus.aluop_i == ALUOP_MULTU);
  assign is_div_op = (bus.aluop_i == ALUOP_DIV)  || (bus.aluop_i == ALUOP_DIVU);
  assign is_sgn_op = (bus.aluop_i == ALUOP_MULT) || (bus.aluop_i == ALUOP_DIV);
  assign is_md     = bus.en_i && (is_mul_op || is_div_op);
  assign is_mt     = bus.en_i && ((bus.aluop_i == ALUOP_MTHI) || (bus.aluop_i == ALUOP_MTLO));

  // Divider works on magnitudes; signs are restored in the final cycle.
  assign abs_a = (is_sgn_op && bus.src_a[31]) ? -bus.src_a : bus.src_a;
  assign abs_b = (is_sgn_op && bus.src_b[31]) ? -bus.src_b : bus.src_b;

  // Multiply: sign/zero-extend to 64 bits so one unsigned multiplier serves both forms.
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod_comb;
  logic [63:0] prod_fin;

  assign mul_a     = {{32{op_sgn & opa[31]}}, opa};
  assign mul_b     = {{32{op_sgn & opb[31]}}, opb};
  assign prod_comb = mul_a * mul_b;

  // Register stages after the multiplier so synthesis can retime the product.
  if (MUL_LAT == 1) begin : g_nopipe
    assign prod_fin = prod_comb;
  end else begin : g_pipe
    logic [63:0] pipe [MUL_LAT-1];
    // Product delay line, one stage per extra busy cycle.
    always_ff @(posedge clk) begin
      pipe[0] <= prod_comb;
      for (int i = 1; i < MUL_LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign prod_fin = pipe[MUL_LAT-2];
  end

  // Restoring divide step: shift in next dividend bit, subtract if it fits.
  logic [32:0] shifted;
  logic        take;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign shifted = {rem, quo[31]};
  assign take    = shifted >= {1'b0, dvs};
  assign q_fix   = (op_sgn && (opa[31] ^ opb[31])) ? -quo : quo;
  assign r_fix   = (op_sgn && opa[31]) ? -rem : rem;

  // Sequencer, operand capture, divider datapath and HI/LO ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      op_div <= 1'b0;
      op_sgn <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
    end else if (bus.flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_md) begin
            state  <= BUSY;
            cnt    <= is_div_op ? DIV_CNT : MUL_CNT;
            op_div <= is_div_op;
            op_sgn <= is_sgn_op;
            opa    <= bus.src_a;
            opb    <= bus.src_b;
            rem    <= '0;
            quo    <= abs_a;
            dvs    <= abs_b;
          end else if (is_mt && !bus.stall_i) begin
            if (bus.aluop_i == ALUOP_MTHI) hi <= bus.src_a;
            else                           lo <= bus.src_a;
          end
        end
        BUSY: begin
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            state <= DONE;
            if (!op_div) begin
              hi <= prod_fin[63:32];
              lo <= prod_fin[31:0];
            end else if (opb == 32'd0) begin
              hi <= opa;
              lo <= 32'hFFFF_FFFF;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end else if (op_div) begin
            quo <= {quo[30:0], take};
            rem <= take ? 32'(shifted - {1'b0, dvs}) : shifted[31:0];
          end
        end
        DONE: begin
          if (!bus.stall_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall_o = ((state == IDLE) && is_md && !bus.flush_i) || (state == BUSY);
  assign bus.busy_o  = (state != IDLE);
  assign bus.hi_o    = hi;
  assign bus.lo_o    = lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: scoreboard of expected {HI,LO} per issued op.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_ctrl_if bus();

  mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] sb [$];
  logic [63:0] e_mon;
  logic [31:0] arch_hi = '0;
  logic [31:0] arch_lo = '0;
  bit          in_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference {HI,LO} from native arithmetic.
  function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    res = '0;
    case (op)
      ALUOP_MULT:  res = 64'(sa * sb_);
      ALUOP_MULTU: res = {32'd0, a} * {32'd0, b};
      ALUOP_DIV, ALUOP_DIVU: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (op == ALUOP_DIV) begin
          q = sa / sb_;
          r = sa % sb_;
          res = {r[31:0], q[31:0]};
        end else res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Pop and compare once on entry to DONE.
  always @(negedge clk) begin
    if (bus.busy_o && !bus.stall_o) begin
      if (!in_done) begin
        if (sb.size() == 0) check("sb_empty", 64'd1, 64'd0);
        else begin
          e_mon = sb.pop_front();
          check("hilo_result", {bus.hi_o, bus.lo_o}, e_mon);
        end
      end
      in_done = 1'b1;
    end else in_done = 1'b0;
  end

  task automatic idle(input int n);
    bus.en_i    = 1'b0;
    bus.aluop_i = 8'h00;
    repeat (n) @(negedge clk);
  endtask

  task automatic issue_md(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold_done);
    logic [63:0] e;
    int n;
    int exp_n;
    e     = model(op, a, b);
    n     = 0;
    exp_n = (op == ALUOP_DIV || op == ALUOP_DIVU) ? 34 : MUL_LAT + 1;
    sb.push_back(e);
    bus.en_i    = 1'b1;
    bus.aluop_i = op;
    bus.src_a   = a;
    bus.src_b   = b;
    #1;
    while (bus.stall_o && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check($sformatf("stall_cycles op=%h", op), 64'(n), 64'(exp_n));
    {arch_hi, arch_lo} = e;
    if (hold_done) begin
      bus.stall_i = 1'b1;
      repeat (4) begin
        @(negedge clk);
        #1;
        check("done_hold_busy", 64'(bus.busy_o), 64'd1);
        check("done_hold_stall", 64'(bus.stall_o), 64'd0);
      end
      bus.stall_i = 1'b0;
    end
    @(negedge clk);
    #1;
    check("leave_done_idle", 64'(bus.busy_o), 64'd0);
    if (hold_done) check("hold_hilo", {bus.hi_o, bus.lo_o}, e);
  endtask

  task automatic flush_div(input int k, input logic [31:0] a, input logic [31:0] b);
    bus.en_i    = 1'b1;
    bus.aluop_i = ALUOP_DIV;
    bus.src_a   = a;
    bus.src_b   = b;
    repeat (k) @(negedge clk);
    #1;
    check($sformatf("busy_before_flush%0d", k), 64'(bus.stall_o), 64'd1);
    bus.flush_i = 1'b1;
    bus.en_i    = 1'b0;
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    check($sformatf("flush%0d_busy", k), 64'(bus.busy_o), 64'd0);
    check($sformatf("flush%0d_stall", k), 64'(bus.stall_o), 64'd0);
    check($sformatf("flush%0d_hilo", k), {bus.hi_o, bus.lo_o}, {arch_hi, arch_lo});
    idle(1);
  endtask

  logic [7:0] ops [4] = '{ALUOP_MULT, ALUOP_MULTU, ALUOP_DIV, ALUOP_DIVU};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.en_i    = 1'b0;
    bus.aluop_i = 8'h00;
    bus.src_a   = '0;
    bus.src_b   = '0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    rst         = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hi", 64'(bus.hi_o), 64'd0);
    check("rst_lo", 64'(bus.lo_o), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_stall", 64'(bus.stall_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // MTHI then MTLO back to back, no stall
    bus.en_i = 1'b1; bus.aluop_i = ALUOP_MTHI; bus.src_a = 32'h1234_5678;
    #1 check("mthi_stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    #1 check("mthi_hi", 64'(bus.hi_o), 64'h1234_5678);
    bus.aluop_i = ALUOP_MTLO; bus.src_a = 32'h9ABC_DEF0;
    #1 check("mtlo_stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    #1 check("mtlo_lo", 64'(bus.lo_o), 64'h9ABC_DEF0);
    check("mtlo_hi_kept", 64'(bus.hi_o), 64'h1234_5678);
    arch_hi = 32'h1234_5678; arch_lo = 32'h9ABC_DEF0;

    // MTHI held off by downstream stall
    bus.stall_i = 1'b1; bus.aluop_i = ALUOP_MTHI; bus.src_a = 32'hA5A5_0F0F;
    repeat (2) @(negedge clk);
    #1 check("mthi_stalled_hi", 64'(bus.hi_o), 64'h1234_5678);
    bus.stall_i = 1'b0;
    @(negedge clk);
    #1 check("mthi_released_hi", 64'(bus.hi_o), 64'hA5A5_0F0F);
    arch_hi = 32'hA5A5_0F0F;
    idle(1);

    issue_md(ALUOP_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
    idle(1);
    issue_md(ALUOP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
    issue_md(ALUOP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 1'b0);   // back-to-back issue
    idle(1);
    issue_md(ALUOP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    issue_md(ALUOP_DIVU,  32'd100, 32'd7, 1'b0);
    issue_md(ALUOP_DIVU,  32'd5, 32'd0, 1'b0);
    issue_md(ALUOP_DIV,   32'hFFFF_FFF7, 32'd0, 1'b0);
    issue_md(ALUOP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue_md(ALUOP_DIV,   32'd7, 32'hFFFF_FFFE, 1'b0);
    issue_md(ALUOP_DIVU,  32'hFFFF_FFFF, 32'd1, 1'b0);
    idle(1);
    issue_md(ALUOP_MULT,  32'd12345, 32'hFFFF_FF00, 1'b1);
    idle(1);

    flush_div(20, 32'd1000, 32'd3);
    flush_div(33, 32'hFFFF_0000, 32'd17);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      issue_md(ops[i % 4], ra, rb, 1'b0);
    end
    idle(1);

    // reset in the middle of a divide
    bus.en_i = 1'b1; bus.aluop_i = ALUOP_DIV; bus.src_a = 32'd99; bus.src_b = 32'd4;
    repeat (10) @(negedge clk);
    rst = 1'b1; bus.en_i = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_hi", 64'(bus.hi_o), 64'd0);
    check("rst_mid_lo", 64'(bus.lo_o), 64'd0);
    check("rst_mid_busy", 64'(bus.busy_o), 64'd0);
    rst = 1'b0;
    idle(2);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
